fir_filter_param: RTL and testbench

- Parametrised streaming FIR filter: NTAPS-tap direct-form, runtime-loadable coefficients, valid-qualified input samples.
- Output is rounded, shifted, saturated and registered.
- Output is suppressed until the delay line holds NTAPS real samples, so the warm-up transient is removed in hardware rather than in the fitness scoring.
- Sits between the signal-memory sample source and the output monitor, in the position of the fixed 4-tap, 32-bit filter it generalises.

---
 rtl/fir_filter_param.sv | 132 +++++++++++++
 tb/tb_fir_filter_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_param.sv
// Parametrised streaming direct-form FIR with loadable coefficients and warm-up suppression.
// Two-stage pipeline: registered products, then sum/round/shift/saturate into the outputs.
module fir_filter_param #(
    parameter int NTAPS = 4,
    parameter int DW    = 32,
    parameter int CW    = 8,
    parameter int OW    = 32,
    parameter int SHIFT = 0,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    output logic          out_sat
);
    localparam int PW   = DW + CW;
    localparam int ACCW = PW + $clog2(NTAPS);
    localparam int RW   = ACCW + 1;
    localparam int CNTW = $clog2(NTAPS + 1);
    localparam logic [RW-1:0] RND = (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic [DW-1:0]   taps [NTAPS];
    logic [CW-1:0]   coef [NTAPS];
    logic [PW-1:0]   prod [NTAPS];
    logic            wr_pend;
    logic [AW-1:0]   wr_addr;
    logic [CW-1:0]   wr_data;
    logic [CNTW-1:0] fill;
    logic            win_valid;
    logic            s1_valid;
    logic [ACCW-1:0] acc;
    logic [RW-1:0]   rnd;
    logic [RW-1:0]   y;
    logic            sat_hit;
    logic [OW-1:0]   y_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
        end else if (in_valid) begin
            taps[0] <= in_data;
            for (int k = 1; k < NTAPS; k++) taps[k] <= taps[k-1];
        end
    end

    // win_valid marks a just-accepted sample whose window is full of real samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill      <= '0;
            win_valid <= 1'b0;
        end else if (clear) begin
            fill      <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= in_valid && (fill >= CNTW'(NTAPS - 1));
            if (in_valid && (fill != CNTW'(NTAPS))) fill <= fill + CNTW'(1);
        end
    end

    // Writes land one edge late so a sample accepted alongside a write still
    // multiplies by the old coefficient when its products are formed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_pend <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
        end else begin
            wr_pend <= coef_we;
            wr_addr <= coef_addr;
            wr_data <= coef_data;
            if (wr_pend) begin
                for (int k = 0; k < NTAPS; k++) begin
                    if (wr_addr == AW'(k)) coef[k] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < NTAPS; k++) prod[k] <= '0;
        end else begin
            s1_valid <= win_valid && !clear;
            for (int k = 0; k < NTAPS; k++) prod[k] <= PW'(taps[k]) * PW'(coef[k]);
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++) acc = acc + ACCW'(prod[k]);
    end

    assign rnd = {1'b0, acc} + RND;
    assign y   = rnd >> SHIFT;

    generate
        if (OW < RW) begin : g_sat
            assign sat_hit = |y[RW-1:OW];
            assign y_out   = sat_hit ? {OW{1'b1}} : y[OW-1:0];
        end else begin : g_nosat
            assign sat_hit = 1'b0;
            assign y_out   = OW'(y);
        end
    endgenerate

    // out_data/out_sat only move on a pulse; clear kills the pulse but keeps them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= s1_valid && !clear;
            if (s1_valid && !clear) begin
                out_data <= y_out;
                out_sat  <= sat_hit;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_param.sv
// Table-driven bench for fir_filter_param: four parameter variants share one stimulus stream,
// each table row selects which variant's outputs it checks.
module tb_fir_filter_param;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [7:0]  coef_data;

    logic        s7_valid, s0_valid, o8_valid, s1_valid;
    logic [31:0] s7_data, s0_data, s1_data;
    logic [7:0]  o8_data;
    logic        s7_sat, s0_sat, o8_sat, s1_sat;

    logic        obs_valid;
    logic [31:0] obs_data;
    logic        obs_sat;

    typedef struct {
        bit          rst;
        bit          clr;
        bit          we;
        logic [1:0]  waddr;
        logic [7:0]  wdata;
        bit          vld;
        logic [31:0] din;
        int          sel;
        bit          ev;
        logic [31:0] ed;
        bit          es;
        string       tag;
    } vec_t;

    vec_t tbl[$];
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   cur_sel = 0;

    always #5 clk = ~clk;

    fir_filter_param #(.NTAPS(4), .DW(32), .CW(8), .OW(32), .SHIFT(7)) u_s7 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(s7_valid), .out_data(s7_data), .out_sat(s7_sat));

    fir_filter_param #(.NTAPS(4), .DW(32), .CW(8), .OW(32), .SHIFT(0)) u_s0 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(s0_valid), .out_data(s0_data), .out_sat(s0_sat));

    fir_filter_param #(.NTAPS(4), .DW(32), .CW(8), .OW(8), .SHIFT(0)) u_o8 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(o8_valid), .out_data(o8_data), .out_sat(o8_sat));

    fir_filter_param #(.NTAPS(4), .DW(32), .CW(8), .OW(32), .SHIFT(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(s1_valid), .out_data(s1_data), .out_sat(s1_sat));

    always_comb begin
        obs_valid = 1'b0;
        obs_data  = '0;
        obs_sat   = 1'b0;
        case (cur_sel)
            0: begin obs_valid = s7_valid; obs_data = s7_data;          obs_sat = s7_sat; end
            1: begin obs_valid = s0_valid; obs_data = s0_data;          obs_sat = s0_sat; end
            2: begin obs_valid = o8_valid; obs_data = {24'd0, o8_data}; obs_sat = o8_sat; end
            default: begin obs_valid = s1_valid; obs_data = s1_data;    obs_sat = s1_sat; end
        endcase
    end

    function automatic void addRow(input int rst, input int clr, input int we, input int wa,
                                   input int wd, input int vld, input int din, input int sel,
                                   input int ev, input int ed, input int es, input string tag);
        vec_t v;
        v.rst   = (rst != 0);
        v.clr   = (clr != 0);
        v.we    = (we != 0);
        v.waddr = 2'(wa);
        v.wdata = 8'(wd);
        v.vld   = (vld != 0);
        v.din   = 32'(din);
        v.sel   = sel;
        v.ev    = (ev != 0);
        v.ed    = 32'(ed);
        v.es    = (es != 0);
        v.tag   = tag;
        tbl.push_back(v);
    endfunction

    // Reset, then load four coefficients with the line idle; outputs stay at reset values.
    function automatic void addCoefs(input int sel, input int c0, input int c1, input int c2,
                                     input int c3, input string tag);
        addRow(1, 0, 1, 0, c0, 0, 0, sel, 0, 0, 0, tag);
        addRow(0, 0, 1, 1, c1, 0, 0, sel, 0, 0, 0, tag);
        addRow(0, 0, 1, 2, c2, 0, 0, sel, 0, 0, 0, tag);
        addRow(0, 0, 1, 3, c3, 0, 0, sel, 0, 0, 0, tag);
    endfunction

    task automatic doReset();
        reset_n   = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.rst) doReset();
        clear     = v.clr;
        coef_we   = v.we;
        coef_addr = v.waddr;
        coef_data = v.wdata;
        in_valid  = v.vld;
        in_data   = v.din;
        cur_sel   = v.sel;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int idx, input bit ev,
                               input logic [31:0] ed, input bit es);
        n_vec++;
        if (obs_valid !== ev || obs_data !== ed || obs_sat !== es) begin
            n_bad++;
            $display("[TB] FAIL %s #%0d (dut %0d): got valid=%0b data=%0d sat=%0b, want valid=%0b data=%0d sat=%0b",
                     tag, idx, cur_sel, obs_valid, obs_data, obs_sat, ev, ed, es);
        end
    endtask

    task automatic drive(input int sel, input bit we, input int wa, input int wd,
                         input bit vld, input int din);
        vec_t v;
        v.rst = 1'b0; v.clr = 1'b0; v.we = we; v.waddr = 2'(wa); v.wdata = 8'(wd);
        v.vld = vld; v.din = 32'(din); v.sel = sel;
        v.ev = 1'b0; v.ed = '0; v.es = 1'b0; v.tag = "hand";
        applyStimulus(v);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expB[11];
        int expD[9];
        int expG[8];
        expB = '{0, 0, 0, 0, 0, 10, 20, 30, 40, 0, 0};
        expD = '{0, 0, 0, 0, 0, 2, 2, 3, 3};
        expG = '{0, 0, 0, 0, 0, 2, 2, 6};

        // Moving average of a constant: (100*32*4 + 64) >> 7 = 100.
        addCoefs(0, 8'h20, 8'h20, 8'h20, 8'h20, "avg");
        for (int s = 0; s < 11; s++)
            addRow(0, 0, 0, 0, 0, int'(s < 8), 100, 0, int'(s >= 5 && s <= 9), (s >= 5) ? 100 : 0, 0, "avg");

        // Impulse response after three zero warm-up samples.
        addCoefs(1, 1, 2, 3, 4, "impulse");
        for (int s = 0; s < 11; s++)
            addRow(0, 0, 0, 0, 0, int'(s < 8), (s == 3) ? 10 : 0, 1, int'(s >= 5 && s <= 9), expB[s], 0, "impulse");

        // Saturation to 8 bits, hold across coefficient rewrites, then recovery.
        addCoefs(2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, "sat");
        for (int s = 0; s < 6; s++)
            addRow(0, 0, 0, 0, 0, int'(s < 4), 255, 2, int'(s == 5), (s == 5) ? 255 : 0, int'(s == 5), "sat");
        for (int k = 0; k < 4; k++)
            addRow(0, 0, 1, k, 0, 0, 0, 2, 0, 255, 1, "sat_hold");
        addRow(0, 0, 0, 0, 0, 1, 1, 2, 0, 255, 1, "sat_hold");
        addRow(0, 0, 0, 0, 0, 0, 0, 2, 0, 255, 1, "sat_hold");
        addRow(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, "unsat");
        addRow(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, "unsat");

        // Round half up with SHIFT=1: 3->2, 4->2, 5->3.
        addCoefs(3, 1, 0, 0, 0, "round");
        for (int s = 0; s < 9; s++)
            addRow(0, 0, 0, 0, 0, int'(s < 6), (s == 3) ? 3 : (s == 4) ? 4 : (s == 5) ? 5 : 0,
                   3, int'(s >= 5 && s <= 7), expD[s], 0, "round");

        // One sample every third cycle: pulses three cycles apart.
        addCoefs(0, 8'h20, 8'h20, 8'h20, 8'h20, "gapped");
        for (int s = 0; s < 19; s++)
            addRow(0, 0, 0, 0, 0, int'(s % 3 == 0), 50, 0, int'(s == 11 || s == 14 || s == 17),
                   (s >= 11) ? 50 : 0, 0, "gapped");

        // clear together with a sample after six samples of 10, then four samples of 1.
        addCoefs(1, 1, 2, 3, 4, "clear");
        for (int s = 0; s < 14; s++)
            addRow(0, int'(s == 6), 0, 0, 0, int'(s < 11), (s < 6) ? 10 : (s == 6) ? 77 : 1, 1,
                   int'(s == 5 || s == 12), (s >= 12) ? 10 : (s >= 5) ? 100 : 0, 0, "clear");

        // A sample accepted on the same edge as a coefficient write uses the old value.
        addCoefs(1, 1, 0, 0, 0, "coef_edge");
        for (int s = 0; s < 8; s++)
            addRow(0, 0, int'(s == 4), 0, 3, int'(s < 6), 2, 1, int'(s >= 5), expG[s], 0, "coef_edge");

        // Reset state of every variant while reset_n is held low.
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        #2;
        for (int s = 0; s < 4; s++) begin
            cur_sel = s;
            #1;
            checkOutput("reset", s, 1'b0, 32'd0, 1'b0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i].tag, i, tbl[i].ev, tbl[i].ed, tbl[i].es);
        end

        // Mid-stream asynchronous reset clears outputs immediately and wipes coefficients.
        doReset();
        for (int k = 0; k < 4; k++) drive(1, 1'b1, k, k + 1, 1'b0, 0);
        for (int s = 0; s < 6; s++) drive(1, 1'b0, 0, 0, s < 4, 10);
        checkOutput("pre_reset", 0, 1'b1, 32'd100, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd10;
        #3 reset_n = 1'b0;
        for (int s = 0; s < 4; s++) begin
            cur_sel = s;
            #1;
            checkOutput("async_reset", s, 1'b0, 32'd0, 1'b0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int s = 0; s < 6; s++) drive(1, 1'b0, 0, 0, s < 4, 10);
        checkOutput("coef_wiped", 0, 1'b1, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
